// File: rtl/hamming_secded_dec_pipe.sv
// hamming_secded_dec_pipe: 2-stage pipelined Hamming SECDED decoder with valid/ready flow control
// and saturating single/double error counters.
module hamming_secded_dec_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W = 16,
  localparam int PAR_W = (DATA_W <= 1) ? 2 : (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 : (DATA_W <= 57) ? 6 : (DATA_W <= 120) ? 7 :
                         (DATA_W <= 247) ? 8 : (DATA_W <= 502) ? 9 : (DATA_W <= 1013) ? 10 : 11,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_single,
  output logic              out_double,
  output logic [PAR_W-1:0]  out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);
  function automatic int dpos(input int i);
    int p = 0;
    int n = -1;
    while (n < i) begin
      p++;
      if ((p & (p - 1)) != 0) n++;
    end
    return p;
  endfunction

  logic s1_valid, s1_pmis, s2_en, in_range, single_c, double_c, xfer;
  logic [PAR_W-1:0] syn, s1_syn;
  logic [DATA_W-1:0] din, s1_data, data_c;

  assign s2_en = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_en;
  assign xfer = out_valid && out_ready;

  always_comb begin
    syn = '0;
    for (int p = 1; p < CODE_W; p++) syn ^= in_code[p-1] ? PAR_W'(p) : '0;
  end

  // Only the data field of the codeword is carried into stage 2; a correctable syndrome
  // that points at a data position flips that bit there.
  for (genvar i = 0; i < DATA_W; i++) begin : g_d
    assign din[i] = in_code[dpos(i)-1];
    assign data_c[i] = s1_data[i] ^ (s1_pmis && s1_syn == PAR_W'(dpos(i)));
  end

  assign in_range = 32'(s1_syn) < CODE_W;
  assign single_c = s1_pmis && in_range;
  assign double_c = !single_c && (s1_syn != '0 || s1_pmis);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_syn <= '0;
      s1_pmis <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= din;
        s1_syn <= syn;
        s1_pmis <= ^in_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_single <= 1'b0;
      out_double <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= data_c;
        out_single <= single_c;
        out_double <= double_c;
        out_syndrome <= s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else begin
      if (xfer && out_single && cnt_single != '1) cnt_single <= cnt_single + 1'b1;
      if (xfer && out_double && cnt_double != '1) cnt_double <= cnt_double + 1'b1;
    end
  end
endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// tb_hamming_secded_dec_pipe: directed bench for the pipelined SECDED decoder (DATA_W=4 with
// CNT_W=16 and CNT_W=2, plus a DATA_W=64 instance).
module tb_hamming_secded_dec_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, cnt_clr = 0;
  logic [7:0] in_code = '0;
  logic in_ready, out_valid, out_single, out_double;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic [15:0] cnt_single, cnt_double;
  logic c_in_ready, c_out_valid, c_out_single, c_out_double;
  logic [3:0] c_out_data;
  logic [2:0] c_out_syndrome;
  logic [1:0] c_cnt_single, c_cnt_double;
  logic w_in_valid = 0, w_out_ready = 1;
  logic [71:0] w_in_code = '0;
  logic w_in_ready, w_out_valid, w_out_single, w_out_double;
  logic [63:0] w_out_data;
  logic [6:0] w_out_syndrome;
  logic [15:0] w_cnt_single, w_cnt_double;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  hamming_secded_dec_pipe #(.DATA_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_single(out_single),
    .out_double(out_double), .out_syndrome(out_syndrome), .cnt_clr(cnt_clr),
    .cnt_single(cnt_single), .cnt_double(cnt_double));

  hamming_secded_dec_pipe #(.DATA_W(4), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_code(in_code),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .out_single(c_out_single),
    .out_double(c_out_double), .out_syndrome(c_out_syndrome), .cnt_clr(cnt_clr),
    .cnt_single(c_cnt_single), .cnt_double(c_cnt_double));

  hamming_secded_dec_pipe #(.DATA_W(64), .CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_code(w_in_code),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_single(w_out_single),
    .out_double(w_out_double), .out_syndrome(w_out_syndrome), .cnt_clr(cnt_clr),
    .cnt_single(w_cnt_single), .cnt_double(w_cnt_double));

  function automatic logic [71:0] enc64(input logic [63:0] d);
    logic [71:0] c = '0;
    logic par;
    int j = 0;
    for (int p = 1; p < 72; p++) if ((p & (p - 1)) != 0) begin c[p-1] = d[j]; j++; end
    for (int k = 0; k < 7; k++) begin
      par = 0;
      for (int p = 1; p < 72; p++) if (((p >> k) & 1) != 0) par ^= c[p-1];
      c[(1 << k) - 1] = par;
    end
    c[71] = ^c[70:0];
    return c;
  endfunction

  task automatic send(input logic [7:0] code, output int lat);
    @(negedge clk); in_valid = 1; in_code = code;
    @(negedge clk); in_valid = 0; in_code = '0; lat = 1;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_total++; if (out_valid !== 0 || out_data !== 0 || out_single !== 0 || out_double !== 0 || out_syndrome !== 0) $display("FAIL reset_out got v=%b d=%h s=%b db=%b syn=%0d want all 0", out_valid, out_data, out_single, out_double, out_syndrome); else n_pass++;
    n_total++; if (cnt_single !== 0 || cnt_double !== 0 || c_cnt_single !== 0 || w_out_valid !== 0) $display("FAIL reset_cnt got cs=%0d cd=%0d ccs=%0d wv=%b want 0", cnt_single, cnt_double, c_cnt_single, w_out_valid); else n_pass++;
    rst_n = 1;
    @(negedge clk);
    n_total++; if (in_ready !== 1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_clean();
    int lat;
    send(8'h55, lat);
    n_total++; if (lat !== 2) $display("FAIL clean_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (out_data !== 4'hB) $display("FAIL clean_data got %h want b", out_data); else n_pass++;
    n_total++; if (out_single !== 0 || out_double !== 0 || out_syndrome !== 0) $display("FAIL clean_flags got s=%b d=%b syn=%0d want 0 0 0", out_single, out_double, out_syndrome); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    send(8'h45, lat);
    n_total++; if (out_data !== 4'hB) $display("FAIL single_data got %h want b", out_data); else n_pass++;
    n_total++; if (out_single !== 1 || out_double !== 0 || out_syndrome !== 3'd5) $display("FAIL single_flags got s=%b d=%b syn=%0d want 1 0 5", out_single, out_double, out_syndrome); else n_pass++;
    @(negedge clk);
    n_total++; if (cnt_single !== 1) $display("FAIL single_cnt got %0d want 1", cnt_single); else n_pass++;
    send(8'hD5, lat);
    n_total++; if (out_data !== 4'hB || out_single !== 1 || out_double !== 0 || out_syndrome !== 0) $display("FAIL overall_bit got d=%h s=%b db=%b syn=%0d want b 1 0 0", out_data, out_single, out_double, out_syndrome); else n_pass++;
    @(negedge clk);
    n_total++; if (cnt_single !== 2) $display("FAIL overall_cnt got %0d want 2", cnt_single); else n_pass++;
  endtask

  task automatic test_double();
    int lat;
    send(8'h44, lat);
    n_total++; if (out_double !== 1 || out_single !== 0 || out_syndrome !== 3'd4) $display("FAIL double_flags got s=%b d=%b syn=%0d want 0 1 4", out_single, out_double, out_syndrome); else n_pass++;
    n_total++; if (out_data !== 4'h9) $display("FAIL double_data got %h want 9", out_data); else n_pass++;
    @(negedge clk);
    n_total++; if (cnt_double !== 1 || cnt_single !== 2) $display("FAIL double_cnt got cd=%0d cs=%0d want 1 2", cnt_double, cnt_single); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes[6] = '{8'h55, 8'h87, 8'h99, 8'hFF, 8'h33, 8'h00};
    logic [3:0] exp_d[6] = '{4'hB, 4'h1, 4'h2, 4'hF, 4'h6, 4'h0};
    logic [3:0] held = '0;
    logic stalled = 0, saw_block = 0;
    int ii = 0, oi = 0;
    for (int c = 0; c < 30 && oi < 6; c++) begin
      @(negedge clk);
      in_valid = ii < 6;
      in_code = ii < 6 ? codes[ii] : 8'h00;
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (stalled) begin
        n_total++; if (!out_valid || out_data !== held) $display("FAIL b2b_hold cycle %0d got v=%b d=%h want 1 %h", c, out_valid, out_data, held); else n_pass++;
      end
      if (!in_ready) saw_block = 1;
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== exp_d[oi] || out_single !== 0 || out_double !== 0) $display("FAIL b2b_word%0d got d=%h s=%b db=%b want %h 0 0", oi, out_data, out_single, out_double, exp_d[oi]); else n_pass++;
        oi++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) ii++;
    end
    in_valid = 0; out_ready = 1;
    n_total++; if (oi !== 6 || ii !== 6) $display("FAIL b2b_count got out=%0d in=%0d want 6 6", oi, ii); else n_pass++;
    n_total++; if (saw_block !== 1) $display("FAIL b2b_backpressure got in_ready_low=%b want 1", saw_block); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 0) $display("FAIL b2b_extra got out_valid=%b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_saturate();
    int lat;
    @(negedge clk); cnt_clr = 1;
    @(negedge clk); cnt_clr = 0;
    n_total++; if (cnt_single !== 0 || cnt_double !== 0 || c_cnt_single !== 0 || c_cnt_double !== 0) $display("FAIL clr got cs=%0d cd=%0d ccs=%0d ccd=%0d want 0", cnt_single, cnt_double, c_cnt_single, c_cnt_double); else n_pass++;
    for (int i = 0; i < 5; i++) begin send(8'h45, lat); @(negedge clk); end
    n_total++; if (c_cnt_single !== 2'd3) $display("FAIL sat_small got %0d want 3", c_cnt_single); else n_pass++;
    n_total++; if (cnt_single !== 5) $display("FAIL sat_wide got %0d want 5", cnt_single); else n_pass++;
    send(8'h44, lat); @(negedge clk);
    send(8'h45, lat);
    cnt_clr = 1;
    @(negedge clk); cnt_clr = 0;
    n_total++; if (cnt_single !== 0 || cnt_double !== 0 || c_cnt_single !== 0) $display("FAIL clr_priority got cs=%0d cd=%0d ccs=%0d want 0", cnt_single, cnt_double, c_cnt_single); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    int lat;
    @(negedge clk); in_valid = 1; in_code = 8'h45;
    @(negedge clk); in_code = 8'h44;
    @(negedge clk); in_valid = 0; in_code = '0; rst_n = 0;
    @(negedge clk); rst_n = 1;
    n_total++; if (out_valid !== 0 || cnt_single !== 0 || cnt_double !== 0 || in_ready !== 1) $display("FAIL midreset got v=%b cs=%0d cd=%0d rdy=%b want 0 0 0 1", out_valid, cnt_single, cnt_double, in_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 0 || cnt_double !== 0) $display("FAIL midreset_flush got v=%b cd=%0d want 0 0", out_valid, cnt_double); else n_pass++;
    send(8'h99, lat);
    n_total++; if (lat !== 2 || out_data !== 4'h2 || out_single !== 0 || out_double !== 0) $display("FAIL midreset_next got lat=%0d d=%h s=%b db=%b want 2 2 0 0", lat, out_data, out_single, out_double); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_wide();
    logic [63:0] d;
    logic [71:0] cw;
    int a, b, lat;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      cw = enc64(d);
      a = $urandom_range(71);
      b = (a + 1 + $urandom_range(70)) % 72;
      cw[a] = ~cw[a];
      if (i >= 4) cw[b] = ~cw[b];
      @(negedge clk); w_in_valid = 1; w_in_code = cw;
      @(negedge clk); w_in_valid = 0; lat = 1;
      while (!w_out_valid && lat < 10) begin @(negedge clk); lat++; end
      n_total++;
      if (i < 4 ? (lat != 2 || w_out_data !== d || w_out_single !== 1 || w_out_double !== 0)
                : (lat != 2 || w_out_single !== 0 || w_out_double !== 1))
        $display("FAIL wide%0d flips=%0d,%0d got lat=%0d d=%h s=%b db=%b want lat=2 d=%h single=%b", i, a, i >= 4 ? b : -1, lat, w_out_data, w_out_single, w_out_double, d, i < 4);
      else n_pass++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_back_to_back();
    test_saturate();
    test_reset_midstream();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
